mont_exp_ctrl: RTL
==================

// Module: mont_exp_ctrl
// PURPOSE
//  Sequencer for modular exponentiation on one shared montgomery multiplier.
//  - Runs left-to-right square-and-multiply: A = R mod M; for each exponent bit
//    from MSB to LSB: A = MM(A,A); if the bit is 1, A = MM(A,X~).
//  - Drives the multiplier's start/in_a/in_b/in_m ports and consumes its result/done.
//  - Sits between the RSA top level and the montgomery datapath.
// PARAMETERS
//  N    1024           operand/modulus width
//  E_W  1024           exponent register width
//  LW   $clog2(E_W+1)  width of in_e_len
// PORTS
//  clk        in   1    clock, all state changes on its rising edge
//  resetn     in   1    asynchronous active-low reset
//  start      in   1    one-cycle request; sampled only in IDLE
//  in_x       in   N    base already in Montgomery form, X~ = X*R mod M
//  in_r       in   N    R mod M, the initial accumulator
//  in_m       in   N    modulus M
//  in_e       in   E_W  exponent
//  in_e_len   in   LW   number of exponent bits to process; values > E_W clamp to E_W
//  result     out  N    final accumulator; held until the next accepted start
//  done       out  1    one-cycle pulse when result becomes valid
//  busy       out  1    high from the cycle after start acceptance until done
//  mm_start   out  1    one-cycle start pulse to the multiplier
//  mm_a       out  N    multiplier operand a
//  mm_b       out  N    multiplier operand b
//  mm_m       out  N    multiplier modulus
//  mm_result  in   N    multiplier result
//  mm_done    in   1    multiplier completion strobe
// BEHAVIOUR
//  - Reset (async, resetn=0): state IDLE; result, mm_a, mm_b, mm_m = 0; done, busy, mm_start = 0.
//  - States: IDLE, CHECK, SQ_START, SQ_WAIT, MUL_START, MUL_WAIT, EXIT_START, EXIT_WAIT, DONE.
//  - IDLE + start: latch X~, M, E and idx = min(in_e_len, E_W); set A = in_r; go to CHECK.
//  - CHECK: idx==0 -> EXIT_START if MONT_EXIT_EN is defined, else DONE; otherwise -> SQ_START.
//  - SQ_START: mm_a = mm_b = A; mm_start = 1 for this cycle only; go to SQ_WAIT.
//  - SQ_WAIT on mm_done: A = mm_result.
//    - If E[idx-1] is 1: -> MUL_START.
//    - Otherwise: idx = idx-1; -> CHECK.
//  - MUL_START: mm_a = A, mm_b = X~; mm_start pulse; go to MUL_WAIT.
//  - MUL_WAIT on mm_done: A = mm_result; idx = idx-1; -> CHECK.
//  - DONE: result = A; done = 1 for one cycle; busy = 0; -> IDLE.
//  - Operand stability: mm_a, mm_b and mm_m (= latched M) are registered and held from
//    the mm_start cycle until mm_done. mm_done in any non-WAIT state is ignored.
//  - start while not IDLE is ignored; latched inputs are not disturbed.
//  - Latency: start in cycle T -> CHECK in T+1.
//    - e_len=0, no exit: done in T+2 with result = in_r.
//    - Otherwise: each multiply adds 2 cycles plus the multiplier latency.
//  - Multiply count: e_len squares plus one multiply per 1-bit in E[e_len-1:0],
//    plus one exit multiply when MONT_EXIT_EN is defined.
//  - Reset mid-operation returns to IDLE with reset values. A late mm_done is then ignored.
// CONFIGURATION
//  - MONT_EXIT_EN defined: after the last bit, EXIT_START issues MM(A,1) with mm_a = A,
//    mm_b = 1. EXIT_WAIT stores mm_result, then -> DONE. result = X^E mod M (normal domain).
//  - MONT_EXIT_EN undefined: EXIT states are unreachable. result = X^E*R mod M (Montgomery domain).
// TESTING
//  Bench setup: N=8, E_W=16, R=256. Behavioural multiplier stub:
//  mm_done 3 cycles after mm_start, mm_result = a*b*R^-1 mod m.
//  1. in_r=0x4D, in_e_len=0, start -> done at T+2; mm_start never pulses;
//     result=0x4D without exit, 0x01 with MONT_EXIT_EN.
//  2. M=0xB3, in_x=0x1B, in_r=0x4D, in_e=0x000B, in_e_len=4 -> 7 mm_start pulses
//     (+1 with exit); result=0x2A without exit, 0x93 with MONT_EXIT_EN.
//  3. Same setup, in_e=0x0000, in_e_len=4 -> exactly 4 squares, no X~ multiplies;
//     result=0x4D without exit, 0x01 with MONT_EXIT_EN.
//  4. Scenario 2 with a second start (in_e=0xFFFF) pulsed during SQ_WAIT -> ignored;
//     pulse count and result match scenario 2.
//  5. resetn=0 for one cycle during MUL_WAIT -> busy, done, mm_start, result all 0;
//     the stub's late mm_done is ignored. A following scenario-2 start completes correctly.

Source files
------------

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl
// Left-to-right square-and-multiply sequencer in front of one shared
// Montgomery multiplier. The accumulator starts at R mod M and, for each
// exponent bit from the top down, is squared and then optionally multiplied
// by the Montgomery-form base.
// Optional feature macro: MONT_EXIT_EN. When defined, a final MM(A,1) brings
// the result back to the normal domain. When undefined, the result is left in
// the Montgomery domain and the EXIT states are never entered.
module mont_exp_ctrl #(
  parameter int N   = 1024,
  parameter int E_W = 1024,
  parameter int LW  = $clog2(E_W + 1)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_r,
  input  logic [N-1:0]   in_m,
  input  logic [E_W-1:0] in_e,
  input  logic [LW-1:0]  in_e_len,
  output logic [N-1:0]   result,
  output logic           done,
  output logic           busy,
  output logic           mm_start,
  output logic [N-1:0]   mm_a,
  output logic [N-1:0]   mm_b,
  output logic [N-1:0]   mm_m,
  input  logic [N-1:0]   mm_result,
  input  logic           mm_done
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SQ_START,
    ST_SQ_WAIT,
    ST_MUL_START,
    ST_MUL_WAIT,
    ST_EXIT_START,
    ST_EXIT_WAIT,
    ST_DONE
  } state_t;

  // Largest exponent length the exponent register can hold.
  localparam logic [LW-1:0]  LEN_MAX = LW'(E_W);
  // Single-bit mask seed used to pick the current exponent bit.
  localparam logic [E_W-1:0] E_ONE   = E_W'(1);
  // Montgomery multiply by one leaves the normal-domain value.
  localparam logic [N-1:0]   N_ONE   = N'(1);

  state_t         r_state;
  state_t         w_next;

  logic [N-1:0]   r_a;
  logic [N-1:0]   r_x;
  logic [N-1:0]   r_m;
  logic [E_W-1:0] r_e;
  logic [LW-1:0]  r_idx;

  logic [N-1:0]   r_result;
  logic           r_done;
  logic           r_busy;
  logic           r_mm_start;
  logic [N-1:0]   r_mm_a;
  logic [N-1:0]   r_mm_b;

  logic [N-1:0]   w_a_next;
  logic [LW-1:0]  w_idx_next;
  logic [LW-1:0]  w_idx_m1;
  logic [LW-1:0]  w_len_clamped;
  logic           w_bit;
  logic           w_accept;

  // A start is only honoured while idle; anything else leaves the latched
  // operands untouched.
  assign w_accept      = (r_state == ST_IDLE) && start;
  assign w_len_clamped = (in_e_len > LEN_MAX) ? LEN_MAX : in_e_len;
  assign w_idx_m1      = r_idx - LW'(1);
  // Exponent bit E[idx-1]; only consulted in SQ_WAIT, where idx is non-zero.
  assign w_bit         = |(r_e & (E_ONE << w_idx_m1));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, next accumulator and next bit index.
  always_comb begin
    w_next     = r_state;
    w_a_next   = r_a;
    w_idx_next = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next     = ST_CHECK;
          w_a_next   = in_r;
          w_idx_next = w_len_clamped;
        end
      end
      ST_CHECK: begin
        if (r_idx == '0) begin
`ifdef MONT_EXIT_EN
          w_next = ST_EXIT_START;
`else
          w_next = ST_DONE;
`endif
        end else begin
          w_next = ST_SQ_START;
        end
      end
      ST_SQ_START: begin
        w_next = ST_SQ_WAIT;
      end
      ST_SQ_WAIT: begin
        if (mm_done) begin
          w_a_next = mm_result;
          if (w_bit) begin
            w_next = ST_MUL_START;
          end else begin
            w_idx_next = w_idx_m1;
            w_next     = ST_CHECK;
          end
        end
      end
      ST_MUL_START: begin
        w_next = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        if (mm_done) begin
          w_a_next   = mm_result;
          w_idx_next = w_idx_m1;
          w_next     = ST_CHECK;
        end
      end
      ST_EXIT_START: begin
        w_next = ST_EXIT_WAIT;
      end
      ST_EXIT_WAIT: begin
        if (mm_done) begin
          w_a_next = mm_result;
          w_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Operand latch: base, modulus and exponent captured on an accepted start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x <= '0;
      r_m <= '0;
      r_e <= '0;
    end else if (w_accept) begin
      r_x <= in_x;
      r_m <= in_m;
      r_e <= in_e;
    end
  end

  // Accumulator and remaining-bit counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a   <= '0;
      r_idx <= '0;
    end else begin
      r_a   <= w_a_next;
      r_idx <= w_idx_next;
    end
  end

  // Multiplier interface: operands are loaded as a START state is entered
  // and then held untouched until the matching WAIT state sees mm_done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mm_start <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
    end else begin
      r_mm_start <= 1'b0;
      case (w_next)
        ST_SQ_START: begin
          r_mm_start <= 1'b1;
          r_mm_a     <= w_a_next;
          r_mm_b     <= w_a_next;
        end
        ST_MUL_START: begin
          r_mm_start <= 1'b1;
          r_mm_a     <= w_a_next;
          r_mm_b     <= r_x;
        end
        ST_EXIT_START: begin
          r_mm_start <= 1'b1;
          r_mm_a     <= w_a_next;
          r_mm_b     <= N_ONE;
        end
        default: begin
          r_mm_start <= 1'b0;
        end
      endcase
    end
  end

  // Status: busy covers CHECK through the last WAIT, done pulses with DONE,
  // and the result register captures the final accumulator on the way in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= (w_next == ST_DONE);
      r_busy <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      if (w_next == ST_DONE) begin
        r_result <= w_a_next;
      end
    end
  end

  assign result   = r_result;
  assign done     = r_done;
  assign busy     = r_busy;
  assign mm_start = r_mm_start;
  assign mm_a     = r_mm_a;
  assign mm_b     = r_mm_b;
  assign mm_m     = r_m;

endmodule
